mat_result_drain: RTL and testbench

- Reader at the output end of the matrix-vector multiplier.
- Detects the multiplier's completion, snapshots all DEPTH accumulated results, and pulses a clear to the MAC array.
- Streams the results one per beat over a valid/ready interface to the downstream consumer (host/UART bridge).
- Frees the multiplier for the next job while the previous results are still draining.

---
 rtl/mat_result_drain.sv | 153 +++++++++++++++
 tb/tb_mat_result_drain.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_result_drain.sv
// Output-side reader for the matrix-vector multiplier: snapshots results on done, clears the MAC array,
// then streams the words over valid/ready. Optional macro DRAIN_CHECKSUM_EN appends a checksum beat.
module mat_result_drain #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RES_WIDTH  = 3 * DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done_in,
    input  logic [DEPTH*RES_WIDTH-1:0]   res_in,
    output logic                         mac_clr,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [RES_WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_idx,
    output logic                         o_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned IDX_W  = $clog2(DEPTH + 1);
    localparam int unsigned CAP_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DRAIN_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_d;
    logic                   done_q;
    logic                   start;
    logic                   hs;
    logic                   cap_load;
    logic [RES_WIDTH-1:0]   cap [DEPTH];
    logic [IDX_W-1:0]       idx_nx;
    logic [RES_WIDTH-1:0]   next_word;

    logic                   mac_clr_d, o_valid_d, o_last_d, busy_d, overrun_d;
    logic [RES_WIDTH-1:0]   o_data_d;
    logic [IDX_W-1:0]       o_idx_d;

`ifdef DRAIN_CHECKSUM_EN
    logic [RES_WIDTH-1:0]   csum, sum_c;

    // Modular sum of the words being captured, registered alongside them.
    always_comb begin
        sum_c = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            sum_c = sum_c + res_in[k*RES_WIDTH +: RES_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (cap_load) begin
            csum <= sum_c;
        end
    end
`endif

    assign start = done_in & ~done_q;
    assign hs    = o_valid & o_ready;

    // Word presented after the current beat is accepted.
    always_comb begin
        idx_nx = o_idx + IDX_W'(1);
`ifdef DRAIN_CHECKSUM_EN
        next_word = (idx_nx == IDX_W'(DEPTH)) ? csum : cap[CAP_AW'(idx_nx)];
`else
        next_word = cap[CAP_AW'(idx_nx)];
`endif
    end

    // Next state and next registered outputs; o_idx doubles as the beat index.
    always_comb begin
        state_d   = state;
        cap_load  = 1'b0;
        mac_clr_d = 1'b0;
        o_valid_d = o_valid;
        o_data_d  = o_data;
        o_idx_d   = o_idx;
        o_last_d  = o_last;
        overrun_d = overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    cap_load  = 1'b1;
                    mac_clr_d = 1'b1;
                    o_valid_d = 1'b1;
                    o_data_d  = res_in[RES_WIDTH-1:0];
                    o_idx_d   = '0;
                    o_last_d  = (LAST_IDX == IDX_W'(0));
                end
            end
            SEND: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (hs) begin
                    if (o_last) begin
                        state_d   = IDLE;
                        o_valid_d = 1'b0;
                        o_last_d  = 1'b0;
                    end else begin
                        o_idx_d  = idx_nx;
                        o_data_d = next_word;
                        o_last_d = (idx_nx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            done_q  <= 1'b1;
            mac_clr <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                cap[k] <= '0;
            end
        end else begin
            state   <= state_d;
            done_q  <= done_in;
            mac_clr <= mac_clr_d;
            o_valid <= o_valid_d;
            o_data  <= o_data_d;
            o_idx   <= o_idx_d;
            o_last  <= o_last_d;
            busy    <= busy_d;
            overrun <= overrun_d;
            if (cap_load) begin
                for (int k = 0; k < int'(DEPTH); k++) begin
                    cap[k] <= res_in[k*RES_WIDTH +: RES_WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_mat_result_drain.sv
// Bench for mat_result_drain: directed scenarios plus randomized traffic against a queue-based model.
module tb_mat_result_drain;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned RW         = 3 * DATA_WIDTH;
    localparam int unsigned IW         = $clog2(DEPTH + 1);
`ifdef DRAIN_CHECKSUM_EN
    localparam int unsigned BEATS = DEPTH + 1;
`else
    localparam int unsigned BEATS = DEPTH;
`endif

    logic                  clk;
    logic                  rst;
    logic                  done_in;
    logic [DEPTH*RW-1:0]   res_in;
    logic                  mac_clr;
    logic                  o_valid;
    logic                  o_ready;
    logic [RW-1:0]         o_data;
    logic [IW-1:0]         o_idx;
    logic                  o_last;
    logic                  busy;
    logic                  overrun;

    mat_result_drain #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .done_in (done_in),
        .res_in  (res_in),
        .mac_clr (mac_clr),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .busy    (busy),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the queue holds the beats still owed for the job in flight.
    logic [RW-1:0] q [$];
    logic          m_prev_done;
    logic          m_ovr;
    logic          m_clr;

    task automatic model_reset();
        q.delete();
        m_prev_done = 1'b1;
        m_ovr       = 1'b0;
        m_clr       = 1'b0;
    endtask

    task automatic model_step(input logic d, input logic r, input logic [DEPTH*RW-1:0] res);
        logic          start;
        logic          active;
        logic [RW-1:0] junk;
        int unsigned   sum;
        start       = d & ~m_prev_done;
        active      = (q.size() != 0);
        m_prev_done = d;
        m_clr       = 1'b0;
        if (start && active) m_ovr = 1'b1;
        if (active && r) junk = q.pop_front();
        if (start && !active) begin
            sum = 0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                q.push_back(res[k*RW +: RW]);
                sum = sum + 32'(res[k*RW +: RW]);
            end
`ifdef DRAIN_CHECKSUM_EN
            q.push_back(RW'(sum));
`endif
            m_clr = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check("o_valid", 32'(o_valid), 32'(q.size() != 0));
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("mac_clr", 32'(mac_clr), 32'(m_clr));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (q.size() != 0) begin
            check("o_data", 32'(o_data), 32'(q[0]));
            check("o_idx", 32'(o_idx), 32'(BEATS) - 32'(q.size()));
            check("o_last", 32'(o_last), 32'(q.size() == 1));
        end
    endtask

    // Entered at a negedge: check, drive the next inputs, predict, advance one cycle.
    task automatic cycle(input logic d, input logic r, input logic [DEPTH*RW-1:0] res);
        check_outputs();
        done_in = d;
        o_ready = r;
        res_in  = res;
        model_step(d, r, res);
        @(negedge clk);
    endtask

    // Asynchronous reset taken between edges; outputs must clear before any clock.
    task automatic do_reset(input logic d);
        done_in = d;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("rst_o_data", 32'(o_data), 32'd0);
        check("rst_o_idx", 32'(o_idx), 32'd0);
        check("rst_o_last", 32'(o_last), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [DEPTH*RW-1:0] pk;
        logic [DEPTH*RW-1:0] ff;
        logic                d;

        rst     = 1'b1;
        done_in = 1'b0;
        o_ready = 1'b0;
        res_in  = '0;
        model_reset();
        @(negedge clk);
        do_reset(1'b0);

        // Basic drain, words 1..DEPTH at full ready.
        for (int k = 0; k < int'(DEPTH); k++) pk[k*RW +: RW] = RW'(k + 1);
        cycle(1'b0, 1'b1, pk);
        repeat (BEATS + 3) cycle(1'b1, 1'b1, pk);

        // Backpressure with ready pattern 1,0,0.
        cycle(1'b0, 1'b0, pk);
        for (int i = 0; i < int'(3 * BEATS + 4); i++) cycle(1'b1, (i % 3) == 0, pk);

        // Snapshot isolation: inputs change to all ones after capture.
        for (int k = 0; k < int'(DEPTH); k++) pk[k*RW +: RW] = RW'((k + 1) << 8);
        ff = '1;
        cycle(1'b0, 1'b1, pk);
        cycle(1'b1, 1'b1, pk);
        repeat (BEATS + 2) cycle(1'b1, 1'b1, ff);

        // Overrun: second rising edge of done mid-drain.
        cycle(1'b0, 1'b1, pk);
        for (int i = 0; i < int'(BEATS + 3); i++) cycle(i != 3, 1'b1, ff);

        // done high across reset release must not capture.
        do_reset(1'b1);
        repeat (4) cycle(1'b1, 1'b1, pk);

        // New job lands on the same edge as the final handshake.
        cycle(1'b0, 1'b1, pk);
        for (int i = 0; i < int'(BEATS + 3); i++) cycle(i != int'(BEATS) - 1, 1'b1, pk);

        // Reset during beat 4, then resume only on a fresh edge.
        do_reset(1'b0);
        cycle(1'b0, 1'b1, pk);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, pk);
        do_reset(1'b1);
        repeat (3) cycle(1'b1, 1'b1, pk);
        cycle(1'b0, 1'b1, pk);
        repeat (BEATS + 2) cycle(1'b1, 1'b1, pk);

        // Checksum wrap case: 0xFFFFFF + 1 + zeros.
        pk = '0;
        pk[RW-1:0]    = '1;
        pk[2*RW-1:RW] = RW'(1);
        cycle(1'b0, 1'b1, pk);
        repeat (BEATS + 2) cycle(1'b1, 1'b1, pk);

        // Randomized traffic with occasional resets.
        d = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) d = ~d;
            for (int k = 0; k < int'(DEPTH); k++) pk[k*RW +: RW] = RW'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset(d);
            else cycle(d, $urandom_range(0, 3) != 0, pk);
        end
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
